// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3/SHAKE input-side control:
// word-select encodings, FSM state type and a ceil-log2 helper.
package sha3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_PAD  = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_DPAD = 2'b01;
    localparam logic [1:0] SEL_PAD  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countern.sv
// Word-within-block counter with synchronous clear (clear wins
// over increment) and asynchronous active-low reset.
module countern #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [N-1:0] o_cnt
);

    logic [N-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + N'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sha3_fsm1_in.sv
// Input-side control of the SHA3/SHAKE core: pops header and message
// words, inserts pad10*1 words and hands complete rate blocks onward.
module sha3_fsm1_in
    import sha3_pkg::*;
#(
    parameter int w      = 64,
    parameter int RATE_W = 21,
    parameter int LEN_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_ready,
    output logic         src_read,
    input  logic [w-1:0] din,
    output logic         ein,
    output logic [1:0]   din_sel,
    output logic [2:0]   pad_byte,
    output logic         pad_last,
    input  logic         core_ready,
    output logic         block_ready,
    output logic         last_block,
    output logic         busy
);

    localparam int              CW    = log2c(RATE_W);
    localparam logic [LEN_W-1:0] WBL  = LEN_W'(w / 8);
    localparam logic [CW-1:0]   LASTW = CW'(RATE_W - 1);

    state_t           r_state;
    state_t           r_ret;
    logic [LEN_W-1:0] r_rb;
    logic             r_pad_done;
    logic             r_last_pend;
    logic             r_block_ready;
    logic             r_last_block;

    state_t           w_state_nxt;
    state_t           w_ret;
    logic [LEN_W-1:0] w_rb_nxt;
    logic [LEN_W-1:0] w_len;
    logic             w_pd_nxt;
    logic             w_clr;
    logic             w_br;
    logic             w_lb;
    logic             w_wlast;
    logic [CW-1:0]    w_wc;
    logic             w_unused_din;

    assign w_len        = din[LEN_W-1:0];
    assign w_unused_din = ^din[w-1:LEN_W];
    assign w_wlast      = (w_wc == LASTW);

    countern #(
        .N (CW)
    ) u_wc (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (w_clr | (ein & w_wlast)),
        .i_inc (ein),
        .o_cnt (w_wc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ret       = r_ret;
        w_rb_nxt    = r_rb;
        w_pd_nxt    = r_pad_done;
        w_clr       = 1'b0;
        w_br        = 1'b0;
        w_lb        = 1'b0;
        src_read    = 1'b0;
        ein         = 1'b0;
        din_sel     = SEL_DATA;
        pad_byte    = 3'd0;
        pad_last    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // header pop is held off while reset is asserted
                if (rst && !src_ready) begin
                    src_read    = 1'b1;
                    w_rb_nxt    = w_len;
                    w_pd_nxt    = 1'b0;
                    w_clr       = 1'b1;
                    w_state_nxt = (w_len != '0) ? ST_LOAD : ST_PAD;
                end
            end
            ST_LOAD: begin
                if (!src_ready) begin
                    src_read = 1'b1;
                    ein      = 1'b1;
                    if (r_rb > WBL) begin
                        w_rb_nxt = r_rb - WBL;
                        w_ret    = ST_LOAD;
                    end else if (r_rb == WBL) begin
                        w_rb_nxt = '0;
                        w_pd_nxt = 1'b0;
                        w_ret    = ST_PAD;
                    end else begin
                        din_sel  = SEL_DPAD;
                        pad_byte = r_rb[2:0];
                        pad_last = w_wlast;
                        w_rb_nxt = '0;
                        w_pd_nxt = 1'b1;
                        w_ret    = ST_PAD;
                    end
                    w_state_nxt = w_ret;
                end
            end
            ST_PAD: begin
                ein         = 1'b1;
                din_sel     = r_pad_done ? SEL_ZERO : SEL_PAD;
                pad_last    = w_wlast;
                w_pd_nxt    = 1'b1;
                w_ret       = ST_PAD;
                w_state_nxt = ST_PAD;
            end
            ST_HOLD: begin
                if (core_ready) begin
                    w_br        = 1'b1;
                    w_lb        = r_last_pend;
                    w_state_nxt = r_ret;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // block completes on the word written at the last rate position
        if (ein && w_wlast) begin
            if (pad_last) begin
                w_ret = ST_IDLE;
            end
            if (core_ready) begin
                w_br        = 1'b1;
                w_lb        = pad_last;
                w_state_nxt = w_ret;
            end else begin
                w_state_nxt = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ret         <= ST_IDLE;
            r_rb          <= '0;
            r_pad_done    <= 1'b0;
            r_last_pend   <= 1'b0;
            r_block_ready <= 1'b0;
            r_last_block  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ret         <= w_ret;
            r_rb          <= w_rb_nxt;
            r_pad_done    <= w_pd_nxt;
            r_block_ready <= w_br;
            r_last_block  <= w_lb;
            if (ein && w_wlast) begin
                r_last_pend <= pad_last;
            end
        end
    end

    assign block_ready = r_block_ready;
    assign last_block  = r_last_block;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sha3_fsm1_in.sv
// Directed bench for sha3_fsm1_in: FIFO model, per-word output log,
// immediate-assertion checks against hand-computed expectations.
module tb_sha3_fsm1_in;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        src_ready = 1'b0;
    logic        core_ready = 1'b1;
    logic [63:0] din = 64'h0;
    logic        src_read;
    logic        ein;
    logic [1:0]  din_sel;
    logic [2:0]  pad_byte;
    logic        pad_last;
    logic        block_ready;
    logic        last_block;
    logic        busy;

    sha3_fsm1_in #(
        .w      (64),
        .RATE_W (21),
        .LEN_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_ready   (src_ready),
        .src_read    (src_read),
        .din         (din),
        .ein         (ein),
        .din_sel     (din_sel),
        .pad_byte    (pad_byte),
        .pad_last    (pad_last),
        .core_ready  (core_ready),
        .block_ready (block_ready),
        .last_block  (last_block),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] fifo[$];
    logic [63:0] tmp;
    int cyc, n_ein, n_rd, n_br;
    int hdr_cyc, first_ein_cyc, last_ein_cyc, br_cyc0, rise_cyc;
    int hold_ein, rd_viol, ein_nr, bad;
    bit last_ein;
    logic [1:0] sel_log[64];
    logic [2:0] pb_log[64];
    logic       pl_log[64];
    logic       lb_log[4];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input bit stall, input bit cr);
        @(posedge clk);
        #1;
        core_ready = cr;
        src_ready  = (fifo.size() == 0) || stall;
        din        = (fifo.size() != 0) ? fifo[0] : 64'h0;
        #3;
        last_ein = ein;
        if (src_read) begin
            if (n_rd == 0) hdr_cyc = cyc;
            n_rd++;
            if (src_ready) rd_viol++;
            if (fifo.size() != 0) tmp = fifo.pop_front();
        end
        if (ein) begin
            if (n_ein == 0) first_ein_cyc = cyc;
            last_ein_cyc = cyc;
            if (n_ein < 64) begin
                sel_log[n_ein] = din_sel;
                pb_log[n_ein]  = pad_byte;
                pl_log[n_ein]  = pad_last;
            end
            if (src_ready) ein_nr++;
            n_ein++;
        end
        if (block_ready) begin
            if (n_br < 4) lb_log[n_br] = last_block;
            if (n_br == 0) br_cyc0 = cyc;
            n_br++;
        end
        cyc++;
    endtask

    task automatic run(input int len, input int ndata, input bit toggle,
                       input bit hold5, input int nblk, input int stop_ein);
        int low;
        bit cr;
        bit done;
        fifo.delete();
        cyc = 0; n_ein = 0; n_rd = 0; n_br = 0;
        hdr_cyc = -1; first_ein_cyc = -1; last_ein_cyc = -1;
        br_cyc0 = -1; rise_cyc = -1;
        hold_ein = 0; rd_viol = 0; ein_nr = 0;
        for (int i = 0; i < 64; i++) begin
            sel_log[i] = 2'bxx; pb_log[i] = 3'bxxx; pl_log[i] = 1'bx;
        end
        for (int i = 0; i < 4; i++) lb_log[i] = 1'bx;
        fifo.push_back({32'hA5A5_5A5A, 32'(len)});
        for (int i = 0; i < ndata; i++) fifo.push_back({$urandom, $urandom});
        low  = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            cr = !(hold5 && n_ein >= 20 && low < 5);
            if (!cr) low++;
            if (hold5 && cr && low == 5 && rise_cyc < 0) rise_cyc = cyc;
            tick(toggle && (cyc % 2 == 1), cr);
            if (hold5 && last_ein && ((!cr && low >= 2) || rise_cyc == cyc - 1))
                hold_ein++;
            if (stop_ein != 0) done = (n_ein >= stop_ein);
            else done = (n_br >= nblk) && !busy;
        end
        chk("run_done", 64'(done), 64'd1);
    endtask

    initial begin
        // reset state, with a word offered so the pop gating is exercised
        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_read", 64'(src_read), 64'd0);
        chk("rst_ein", 64'(ein), 64'd0);
        chk("rst_din_sel", 64'(din_sel), 64'd0);
        chk("rst_pad_byte", 64'(pad_byte), 64'd0);
        chk("rst_pad_last", 64'(pad_last), 64'd0);
        chk("rst_block_ready", 64'(block_ready), 64'd0);
        chk("rst_last_block", 64'(last_block), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        src_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // len=0: header only, one all-pad block
        run(0, 0, 0, 0, 1, 0);
        chk("l0_n_ein", 64'(n_ein), 64'd21);
        chk("l0_n_rd", 64'(n_rd), 64'd1);
        chk("l0_sel0", 64'(sel_log[0]), 64'd2);
        bad = 0;
        for (int i = 1; i < 21; i++) if (sel_log[i] !== 2'b11) bad++;
        chk("l0_zero_words", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) if (pl_log[i] !== 1'b0) bad++;
        chk("l0_early_pad_last", 64'(bad), 64'd0);
        chk("l0_pad_last20", 64'(pl_log[20]), 64'd1);
        chk("l0_n_br", 64'(n_br), 64'd1);
        chk("l0_last_block", 64'(lb_log[0]), 64'd1);

        // len=8: one data word ending on a word boundary
        run(8, 1, 0, 0, 1, 0);
        chk("l8_n_rd", 64'(n_rd), 64'd2);
        chk("l8_n_ein", 64'(n_ein), 64'd21);
        chk("l8_sel0", 64'(sel_log[0]), 64'd0);
        chk("l8_sel1", 64'(sel_log[1]), 64'd2);
        chk("l8_pb1", 64'(pb_log[1]), 64'd0);
        chk("l8_sel2", 64'(sel_log[2]), 64'd3);
        chk("l8_pad_last20", 64'(pl_log[20]), 64'd1);
        chk("l8_first_ein_lat", 64'(first_ein_cyc - hdr_cyc), 64'd1);
        chk("l8_br_lat", 64'(br_cyc0 - last_ein_cyc), 64'd1);
        chk("l8_last_block", 64'(lb_log[0]), 64'd1);

        // len=13: domain byte inside the second data word
        run(13, 2, 0, 0, 1, 0);
        chk("l13_n_rd", 64'(n_rd), 64'd3);
        chk("l13_sel1", 64'(sel_log[1]), 64'd1);
        chk("l13_pb1", 64'(pb_log[1]), 64'd5);
        chk("l13_sel2", 64'(sel_log[2]), 64'd3);
        chk("l13_n_br", 64'(n_br), 64'd1);

        // len=167 with src_ready toggling: domain and final bit share word 20
        run(167, 21, 1, 0, 1, 0);
        chk("l167_n_rd", 64'(n_rd), 64'd22);
        chk("l167_n_ein", 64'(n_ein), 64'd21);
        chk("l167_sel19", 64'(sel_log[19]), 64'd0);
        chk("l167_sel20", 64'(sel_log[20]), 64'd1);
        chk("l167_pb20", 64'(pb_log[20]), 64'd7);
        chk("l167_pad_last20", 64'(pl_log[20]), 64'd1);
        chk("l167_ein_stalled", 64'(ein_nr), 64'd0);
        chk("l167_rd_viol", 64'(rd_viol), 64'd0);
        chk("l167_n_br", 64'(n_br), 64'd1);
        chk("l167_last_block", 64'(lb_log[0]), 64'd1);

        // len=168: full data block, core stalls, then an all-pad block
        run(168, 21, 0, 1, 2, 0);
        chk("l168_n_rd", 64'(n_rd), 64'd22);
        chk("l168_n_ein", 64'(n_ein), 64'd42);
        chk("l168_sel20", 64'(sel_log[20]), 64'd0);
        chk("l168_pad_last20", 64'(pl_log[20]), 64'd0);
        chk("l168_sel21", 64'(sel_log[21]), 64'd2);
        chk("l168_sel22", 64'(sel_log[22]), 64'd3);
        chk("l168_pad_last41", 64'(pl_log[41]), 64'd1);
        chk("l168_hold_ein", 64'(hold_ein), 64'd0);
        chk("l168_br_after_rise", 64'(br_cyc0 - rise_cyc), 64'd1);
        chk("l168_n_br", 64'(n_br), 64'd2);
        chk("l168_lb0", 64'(lb_log[0]), 64'd0);
        chk("l168_lb1", 64'(lb_log[1]), 64'd1);

        // reset asserted in the middle of the padding phase
        run(13, 2, 0, 0, 1, 5);
        @(posedge clk);
        #2;
        chk("mid_busy_pre", 64'(busy), 64'd1);
        chk("mid_sel_pre", 64'(din_sel), 64'd3);
        src_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_src_read", 64'(src_read), 64'd0);
        chk("mid_ein", 64'(ein), 64'd0);
        chk("mid_din_sel", 64'(din_sel), 64'd0);
        chk("mid_pad_byte", 64'(pad_byte), 64'd0);
        chk("mid_pad_last", 64'(pad_last), 64'd0);
        chk("mid_block_ready", 64'(block_ready), 64'd0);
        chk("mid_last_block", 64'(last_block), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        src_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // recovery after reset: counters start from zero again
        run(8, 1, 0, 0, 1, 0);
        chk("rec_n_ein", 64'(n_ein), 64'd21);
        chk("rec_sel1", 64'(sel_log[1]), 64'd2);
        chk("rec_pad_last20", 64'(pl_log[20]), 64'd1);
        chk("rec_last_block", 64'(lb_log[0]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
